// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one pipelined adder among NREQ requesters.
// Each issue is tagged with its requester id and its result is routed back after LAT+1 cycles.
//
// state    | meaning
// WAIT_RDY | after reset, waiting for the adder to report ready
// RUN      | granting one operand set per cycle
// DRAIN    | hold requested, no grants, waiting for in-flight ops to return
// HELD     | adder empty and parked until hold drops
module adder_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int LAT  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic              hold,
    output logic [NREQ-1:0]   gnt,
    output logic              add_start,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic              add_ready,
    input  logic [W-1:0]      add_s,
    input  logic              add_cout,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_s,
    output logic              rsp_cout,
    output logic              busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LAT + 2);

    typedef enum logic [1:0] {
        WAIT_RDY,
        RUN,
        DRAIN,
        HELD
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic [LAT-1:0] tag_vld;
    logic [IDW-1:0] tag_id [LAT];
    logic [CW-1:0]  inflight;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin : arb
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!win_found && req[IDW'(idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        gnt       = '0;
        add_start = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state == RUN && !hold && add_ready && win_found) begin
            gnt[win_id] = 1'b1;
            add_start   = 1'b1;
            add_a       = req_a[win_id*W +: W];
            add_b       = req_b[win_id*W +: W];
            add_cin     = req_cin[win_id];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_RDY: if (add_ready) state_nxt = RUN;
            RUN:      if (hold) state_nxt = DRAIN;
            DRAIN: begin
                if (!hold) state_nxt = RUN;
                else if (inflight == '0) state_nxt = HELD;
            end
            HELD:     if (!hold) state_nxt = RUN;
            default:  state_nxt = WAIT_RDY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_RDY;
            ptr   <= IDW'(NREQ - 1);
        end else begin
            state <= state_nxt;
            if (add_start) ptr <= win_id;
        end
    end

    // Tag pipe runs in lockstep with the adder pipeline; it never stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld <= '0;
            for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_vld[0] <= add_start;
            tag_id[0]  <= win_id;
            for (int i = 1; i < LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_s     <= '0;
            rsp_cout  <= 1'b0;
        end else if (tag_vld[LAT-1]) begin
            rsp_valid <= NREQ'(1) << tag_id[LAT-1];
            rsp_s     <= add_s;
            rsp_cout  <= add_cout;
        end else begin
            rsp_valid <= '0;
        end
    end

    // Counts an op from issue until its response pulse has been presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            unique case ({add_start, |rsp_valid})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign busy = (inflight != '0);

endmodule

// File: tb/tb_adder_rr_sched.sv
// Bench for adder_rr_sched: pipelined adder model plus a queue-based reference
// that predicts grants, issue operands and responses cycle by cycle.
module tb_adder_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int LAT  = 3;

    localparam int M_WAIT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HELD  = 3;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              hold;
    logic [NREQ-1:0]   gnt;
    logic              add_start;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic              add_ready;
    logic [W-1:0]      add_s;
    logic              add_cout;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_s;
    logic              rsp_cout;
    logic              busy;

    adder_rr_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .hold      (hold),
        .gnt       (gnt),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_ready (add_ready),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Adder: LAT register stages, result of cycle-t operands visible in cycle t+LAT.
    logic [W:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= add_start ? ({1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin}) : '0;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_s    = apipe[LAT-1][W-1:0];
    assign add_cout = apipe[LAT-1][W];

    typedef struct {
        int         g;
        int         due;
        int         id;
        logic [W:0] sum;
    } exp_t;

    int         n_checks;
    int         n_fail;
    int         mcyc;
    int         m_mode;
    int         m_ptr;
    logic [W-1:0] m_s;
    logic       m_cout;
    exp_t       expq[$];
    logic [23:0] exp_vec;

    logic [8:0] ops [NREQ][1024];
    int         head [NREQ];
    int         tail [NREQ];
    logic       act [NREQ];

    function automatic logic [23:0] obs_vec();
        return {gnt, add_start, add_a, add_b, add_cin, rsp_valid, rsp_s, rsp_cout, busy};
    endfunction

    task automatic model_reset();
        m_mode = M_WAIT;
        m_ptr  = NREQ - 1;
        m_s    = '0;
        m_cout = 1'b0;
        expq.delete();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
            act[i]  = 1'b0;
        end
        req     = '0;
        req_a   = '0;
        req_b   = '0;
        req_cin = '0;
    endtask

    task automatic push_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        ops[id][tail[id]] = {a, b, c};
        tail[id]++;
    endtask

    // A requester raises req with probability pct and then holds it until its grant.
    task automatic drive_reqs(input int pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!act[i] && head[i] < tail[i] && int'($urandom_range(99)) < pct) act[i] = 1'b1;
            req[i] = act[i];
            if (act[i]) begin
                req_a[i*W +: W] = ops[i][head[i]][8:5];
                req_b[i*W +: W] = ops[i][head[i]][4:1];
                req_cin[i]      = ops[i][head[i]][0];
            end else begin
                req_a[i*W +: W] = W'($urandom);
                req_b[i*W +: W] = W'($urandom);
                req_cin[i]      = 1'($urandom);
            end
        end
    endtask

    task automatic model_cycle();
        logic          mbusy;
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] erv;
        logic [W-1:0]  ea;
        logic [W-1:0]  eb;
        logic          ec;
        int            w;
        logic          found;
        logic [8:0]    op;
        mbusy = 1'b0;
        foreach (expq[k]) if (expq[k].g < mcyc) mbusy = 1'b1;
        erv = '0;
        if (expq.size() > 0 && expq[0].due == mcyc) begin
            erv    = NREQ'(1) << expq[0].id;
            m_s    = expq[0].sum[W-1:0];
            m_cout = expq[0].sum[W];
            void'(expq.pop_front());
        end
        eg = '0; ea = '0; eb = '0; ec = 1'b0; found = 1'b0; w = 0;
        if (m_mode == M_RUN && !hold && add_ready) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && act[(m_ptr + k) % NREQ]) begin
                    found = 1'b1;
                    w     = (m_ptr + k) % NREQ;
                end
            end
        end
        if (found) begin
            op     = ops[w][head[w]];
            eg[w]  = 1'b1;
            ea     = op[8:5];
            eb     = op[4:1];
            ec     = op[0];
            expq.push_back('{mcyc, mcyc + LAT + 1, w, (W+1)'(ea) + (W+1)'(eb) + (W+1)'(ec)});
            m_ptr  = w;
            head[w]++;
            act[w] = 1'b0;
        end
        case (m_mode)
            M_WAIT:  if (add_ready) m_mode = M_RUN;
            M_RUN:   if (hold) m_mode = M_DRAIN;
            M_DRAIN: if (!hold) m_mode = M_RUN; else if (!mbusy) m_mode = M_HELD;
            default: if (!hold) m_mode = M_RUN;
        endcase
        exp_vec = {eg, found, ea, eb, ec, erv, m_s, m_cout, mbusy};
        mcyc++;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        hold      = 1'b0;
        add_ready = 1'b0;
        model_reset();
        clear_reqs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic all_done();
        logic d;
        d = (expq.size() == 0);
        for (int i = 0; i < NREQ; i++) if (head[i] < tail[i] || act[i]) d = 1'b0;
        return d;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; hold = 1'b0; add_ready = 1'b0;
        model_reset();
        clear_reqs();
        #1;
        n_checks++;
        if (obs_vec() !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_async got=%h want=%h", obs_vec(), 24'h0);
        end
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_held got=%h want=%h", obs_vec(), 24'h0);
        end
        push_op(1, 4'd5, 4'd9, 1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            add_ready = (i >= 3);
            drive_reqs(100);
            #1;
            model_cycle();
            n_checks++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_wait_rdy cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        apply_reset();
        push_op(0, 4'd3, 4'd4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add_ready = 1'b1;
            drive_reqs(100);
            #1;
            model_cycle();
            n_checks++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL single cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) push_op(i, 4'd7, 4'd8, 1'b1);
        for (int i = 0; i < 14; i++) begin
            add_ready = 1'b1;
            drive_reqs(100);
            #1;
            model_cycle();
            n_checks++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL round_robin cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 4; k++) push_op(2, W'(k + 9), W'(k * 3), k[0]);
        for (int i = 0; i < 10; i++) begin
            add_ready = 1'b1;
            drive_reqs(100);
            #1;
            model_cycle();
            n_checks++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure_hold();
        apply_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) push_op(i, W'($urandom), W'($urandom), 1'($urandom));
        for (int i = 0; i < 50; i++) begin
            add_ready = !(i == 4 || i == 5);
            hold      = (i >= 9 && i < 18) || i == 24 || i == 25;
            drive_reqs(100);
            #1;
            model_cycle();
            n_checks++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL backpressure_hold cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec);
            end
            @(negedge clk);
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_midop();
        apply_reset();
        push_op(3, 4'd15, 4'd15, 1'b1);
        push_op(0, 4'd1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            add_ready = 1'b1;
            drive_reqs(100);
            #1;
            model_cycle();
            n_checks++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_midop_issue cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec);
            end
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_midop_clear got=%h want=%h", obs_vec(), 24'h0);
        end
        model_reset();
        clear_reqs();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            add_ready = 1'b1;
            drive_reqs(100);
            #1;
            model_cycle();
            n_checks++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_midop_after cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_exhaustive();
        int cyc;
        apply_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 512; k++) begin
                ops[i][k] = 9'((k + i * 128) % 512);
                tail[i]   = k + 1;
            end
        cyc = 0;
        while (!all_done() && cyc < 8000) begin
            add_ready = ($urandom_range(7) != 0);
            drive_reqs(60);
            #1;
            model_cycle();
            n_checks++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL exhaustive cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (!all_done()) begin
            n_fail++;
            $display("FAIL exhaustive_complete got=%0d pending want=0 (cycle budget %0d)", expq.size(), cyc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mcyc     = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_backpressure_hold();
        test_reset_midop();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
